// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one pipelined signed Q1.(BITSIZE-1)
// fractional multiplier between NREQ requesters, acking each result.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req        per-requester level request, held until its ack
//   op_a/op_b  packed operands, requester i at [i*BITSIZE +: BITSIZE]
//   ack        one-hot, one-cycle pulse marking result valid for requester
//   result     saturated fractional product, held between acks
//   result_id  index of the requester being acked, held between acks
//   busy       high while any operation is in the pipeline
module mult_arbiter #(
    parameter int BITSIZE = 16,
    parameter int NREQ    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*BITSIZE-1:0] op_a,
    input  logic [NREQ*BITSIZE-1:0] op_b,
    output logic [NREQ-1:0]         ack,
    output logic [BITSIZE-1:0]      result,
    output logic [2:0]              result_id,
    output logic                    busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = 2 * BITSIZE;

    logic [IW-1:0]             ptr;
    logic [NREQ-1:0]           pending;
    logic [NREQ-1:0]           eligible;
    logic                      gnt_vld;
    logic [IW-1:0]             gnt_id;
    logic [IW:0]               scan;
    logic [NREQ-1:0]           gnt_mask;
    logic [NREQ-1:0]           clr_mask;

    logic                      s1_vld;
    logic [IW-1:0]             s1_id;
    logic signed [BITSIZE-1:0] s1_a;
    logic signed [BITSIZE-1:0] s1_b;

    logic                      s2_vld;
    logic [IW-1:0]             s2_id;
    logic signed [PW-1:0]      s2_p;

    logic                      out_vld;
    logic [BITSIZE-1:0]        sat;

    // A requester whose result is in flight stays ineligible until the
    // edge that registers its ack, which also clears its pending bit.
    assign eligible = req & ~pending;

    // Scan from ptr upward, wrapping at NREQ; first eligible wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (IW+1)'(k);
            if (scan >= (IW+1)'(NREQ))
                scan = scan - (IW+1)'(NREQ);
            if (!gnt_vld && eligible[scan[IW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = scan[IW-1:0];
            end
        end
    end

    assign gnt_mask = gnt_vld ? (NREQ'(1) << gnt_id) : '0;
    assign clr_mask = s2_vld  ? (NREQ'(1) << s2_id)  : '0;

    // Product >>> (BITSIZE-1) is bits [PW-2:BITSIZE-1]; it only overflows
    // when the top two product bits differ (min*min in practice).
    always_comb begin
        if (s2_p[PW-1] != s2_p[PW-2])
            sat = s2_p[PW-1] ? {1'b1, {(BITSIZE-1){1'b0}}}
                             : {1'b0, {(BITSIZE-1){1'b1}}};
        else
            sat = s2_p[PW-2:BITSIZE-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            pending   <= '0;
            s1_vld    <= 1'b0;
            s1_id     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s2_vld    <= 1'b0;
            s2_id     <= '0;
            s2_p      <= '0;
            out_vld   <= 1'b0;
            ack       <= '0;
            result    <= '0;
            result_id <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | gnt_mask;

            if (gnt_vld)
                ptr <= (gnt_id == IW'(NREQ-1)) ? '0 : gnt_id + IW'(1);

            s1_vld <= gnt_vld;
            if (gnt_vld) begin
                s1_id <= gnt_id;
                s1_a  <= op_a[gnt_id*BITSIZE +: BITSIZE];
                s1_b  <= op_b[gnt_id*BITSIZE +: BITSIZE];
            end

            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_id <= s1_id;
                s2_p  <= PW'(s1_a) * PW'(s1_b);
            end

            out_vld <= s2_vld;
            ack     <= clr_mask;
            if (s2_vld) begin
                result    <= sat;
                result_id <= 3'(s2_id);
            end
        end
    end

    assign busy = s1_vld | s2_vld | out_vld;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: table vectors, directed corner sequences and random
// traffic, all checked every cycle against a grant-queue reference model.
module tb_mult_arbiter;

    localparam int B = 16;
    localparam int N = 4;
    localparam longint SC = 64'sd1 << (B-1);

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*B-1:0] op_a;
    logic [N*B-1:0] op_b;
    logic [N-1:0]   ack;
    logic [B-1:0]   result;
    logic [2:0]     result_id;
    logic           busy;

    always #5 clk = ~clk;

    mult_arbiter #(.BITSIZE(B), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .ack(ack), .result(result), .result_id(result_id), .busy(busy)
    );

    typedef struct {
        int         id;
        logic [B-1:0] val;
        int         age;
    } fl_t;

    typedef struct {
        int         id;
        logic [B-1:0] a;
        logic [B-1:0] b;
        logic [B-1:0] exp;
    } vec_t;

    fl_t          q[$];
    bit           m_pend[N];
    int           m_ptr;
    logic [N-1:0] e_ack;
    logic [B-1:0] e_res;
    logic [2:0]   e_id;
    int           nvec;
    int           nfail;
    bit           auto_drop;

    // Real-valued fractional multiply: floor(a*b / 2^(B-1)), clipped high.
    function automatic logic [B-1:0] fmul(logic [B-1:0] a, logic [B-1:0] b);
        longint p;
        longint r;
        p = longint'($signed(a)) * longint'($signed(b));
        r = p / SC;
        if (p < 0 && (p % SC) != 0)
            r = r - 1;
        if (r > SC - 1)
            r = SC - 1;
        return r[B-1:0];
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // One clock: model decides the grant from pre-edge inputs, then
    // DUT outputs are compared 1ns after the edge.
    task automatic step();
        int g;
        logic [B-1:0] ga;
        logic [B-1:0] gb;
        g  = -1;
        ga = '0;
        gb = '0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && req[i] && !m_pend[i])
                    g = i;
            end
        end
        if (g >= 0) begin
            ga = op_a[g*B +: B];
            gb = op_b[g*B +: B];
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_ptr = 0;
            e_ack = '0;
            e_res = '0;
            e_id  = '0;
        end else begin
            e_ack = '0;
            foreach (q[j]) q[j].age++;
            while (q.size() > 0 && q[0].age > 2) void'(q.pop_front());
            foreach (q[j]) begin
                if (q[j].age == 2) begin
                    e_ack[q[j].id] = 1'b1;
                    e_res = q[j].val;
                    e_id  = 3'(q[j].id);
                    m_pend[q[j].id] = 1'b0;
                end
            end
            if (g >= 0) begin
                q.push_back('{id: g, val: fmul(ga, gb), age: 0});
                m_pend[g] = 1'b1;
                m_ptr = (g + 1) % N;
            end
        end
        chk("ack", 32'(ack), 32'(e_ack));
        chk("result", 32'(result), 32'(e_res));
        chk("result_id", 32'(result_id), 32'(e_id));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        if (auto_drop)
            req = req & ~ack;
    endtask

    task automatic set_ops(int id, logic [B-1:0] a, logic [B-1:0] b);
        op_a[id*B +: B] = a;
        op_b[id*B +: B] = b;
    endtask

    vec_t vt[$];
    int   ids[$];
    int   lat;
    int   cnt;

    initial begin
        nvec      = 0;
        nfail     = 0;
        auto_drop = 1'b1;
        rst       = 1'b1;
        req       = '0;
        op_a      = '0;
        op_b      = '0;
        m_ptr     = 0;
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single requests through the table, latency and value checks.
        vt.push_back('{0, 16'h4000, 16'h4000, 16'h2000});
        vt.push_back('{1, 16'h8000, 16'h8000, 16'h7FFF});
        vt.push_back('{2, 16'h8000, 16'h7FFF, 16'h8001});
        vt.push_back('{3, 16'hC000, 16'h4000, 16'hE000});
        vt.push_back('{0, 16'hFFFF, 16'h0001, 16'hFFFF});
        vt.push_back('{1, 16'h7FFF, 16'h7FFF, 16'h7FFE});
        vt.push_back('{2, 16'h0000, 16'h8000, 16'h0000});
        foreach (vt[v]) begin
            set_ops(vt[v].id, vt[v].a, vt[v].b);
            req[vt[v].id] = 1'b1;
            for (lat = 1; lat <= 6; lat++) begin
                step();
                if (ack[vt[v].id]) break;
            end
            chk("tbl_latency", 32'(lat), 32'd3);
            chk("tbl_result", 32'(result), 32'(vt[v].exp));
            chk("tbl_id", 32'(result_id), 32'(vt[v].id));
            repeat (2) step();
        end

        // Simultaneous requests right after reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            set_ops(i, 16'(16'h1000 * (i + 1)), 16'h3000);
        req = '1;
        ids.delete();
        repeat (8) begin
            step();
            if (ack != '0) ids.push_back(int'(result_id));
        end
        chk("simul_count", 32'(ids.size()), 32'd4);
        foreach (ids[j]) chk("simul_order", 32'(ids[j]), 32'(j));

        // Fairness across the wrap with ptr at 3.
        set_ops(2, 16'h2000, 16'h2000);
        req = 4'b0100;
        for (int t = 0; t < 6 && req[2]; t++) step();
        chk("wrap_setup", 32'(req), 32'd0);
        set_ops(3, 16'h9000, 16'h5000);
        set_ops(0, 16'h7000, 16'hA000);
        auto_drop = 1'b0;
        req = 4'b1001;
        ids.delete();
        repeat (12) begin
            step();
            if (ack != '0) ids.push_back(int'(result_id));
        end
        req = '0;
        auto_drop = 1'b1;
        repeat (4) step();
        chk("wrap_count", 32'(ids.size()), 32'd7);
        if (ids.size() > 0) chk("wrap_first", 32'(ids[0]), 32'd3);
        for (int j = 1; j < ids.size(); j++)
            chk("wrap_alt", 32'(ids[j] == ids[j-1]), 32'd0);

        // Drop req while pending: ack still arrives exactly once.
        set_ops(1, 16'hA000, 16'h6000);
        req = 4'b0010;
        step();
        req[1] = 1'b0;
        cnt = 0;
        repeat (6) begin
            step();
            if (ack[1]) begin
                cnt++;
                chk("drop_result", 32'(result), 32'(fmul(16'hA000, 16'h6000)));
            end
        end
        chk("drop_count", 32'(cnt), 32'd1);

        // Reset with two operations in flight.
        set_ops(0, 16'h4000, 16'h4000);
        set_ops(1, 16'h5000, 16'h5000);
        req = 4'b0011;
        step();
        step();
        rst = 1'b1;
        req = 4'b0100;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_id", 32'(result_id), 32'd0);
        rst = 1'b0;
        set_ops(3, 16'h1111, 16'h2222);
        req = 4'b1010;
        ids.delete();
        cnt = 0;
        repeat (10) begin
            step();
            if (ack[0] || ack[2]) cnt++;
            if (ack != '0) ids.push_back(int'(result_id));
        end
        chk("rst_stale", 32'(cnt), 32'd0);
        chk("rst_count", 32'(ids.size()), 32'd2);
        if (ids.size() > 0) chk("rst_first", 32'(ids[0]), 32'd1);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(2) == 0) begin
                    if ($urandom_range(5) == 0)
                        set_ops(i, 16'h8000, 16'($urandom_range(1) ? 16'h8000 : $urandom));
                    else
                        set_ops(i, 16'($urandom), 16'($urandom));
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(19) == 0) begin
                    req[i] = 1'b0;
                end
            end
            step();
        end
        req = '0;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
